// File: rtl/sdram_master.sv
// sdram_master: Avalon-MM memory-copy master.
// When started, it copies num_words 32-bit words from src_addr to dest_addr.
// Each word is copied with one read, a wait for readdatavalid, and then one write.
// Every bus output comes straight from a flop.
// The next-state decode looks ahead, so each output is valid in the same cycle as its state.
module sdram_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        copying,
    input  logic [31:0] src_addr,
    input  logic [31:0] dest_addr,
    input  logic [31:0] num_words,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dest_q, dest_d;
    logic [31:0] num_q, num_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        copying_q, copying_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode.
    // DONE waits for enable to drop, so a held enable cannot restart the copy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = (num_words == 32'd0) ? DONE : RD_REQ;
            RD_REQ:  if (!master_waitrequest) state_d = RD_WAIT;
            RD_WAIT: if (master_readdatavalid) state_d = WR_REQ;
            WR_REQ:  if (!master_waitrequest)
                         state_d = (idx_q + 32'd1 == num_q) ? DONE : RD_REQ;
            DONE:    if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Copy parameters are latched once at start.
    // The word index advances on each accepted write.
    always_comb begin
        src_d   = src_q;
        dest_d  = dest_q;
        num_d   = num_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (enable) begin
                src_d  = src_addr;
                dest_d = dest_addr;
                num_d  = num_words;
                idx_d  = 32'd0;
            end
            RD_WAIT: if (master_readdatavalid) wdata_d = master_readdata;
            WR_REQ:  if (!master_waitrequest) idx_d = idx_q + 32'd1;
            default: ;
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with it.
    // The address wraps modulo 2^32.
    always_comb begin
        read_d    = (state_d == RD_REQ);
        write_d   = (state_d == WR_REQ);
        copying_d = (state_d == RD_REQ) || (state_d == RD_WAIT) || (state_d == WR_REQ);
        addr_d    = addr_q;
        if (state_d == RD_REQ)      addr_d = src_d  + {idx_d[29:0], 2'b00};
        else if (state_d == WR_REQ) addr_d = dest_d + {idx_d[29:0], 2'b00};
    end

    // Datapath and output registers.
    // All of them are cleared by reset, so a reset aborts any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q     <= '0;
            dest_q    <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            copying_q <= 1'b0;
        end else begin
            src_q     <= src_d;
            dest_q    <= dest_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            read_q    <= read_d;
            write_q   <= write_d;
            copying_q <= copying_d;
        end
    end

    assign master_address   = addr_q;
    assign master_read      = read_q;
    assign master_write     = write_q;
    assign master_writedata = wdata_q;
    assign copying          = copying_q;

endmodule

// File: tb/tb_sdram_master.sv
// Testbench for sdram_master.
// A transaction-level model expects a read and a write per word, in order, at src+4k and dest+4k.
// A per-cycle compare process checks the DUT against that model.
// Directed sequences add literal address/data checks that pin the model.
`timescale 1ns/1ps
module tb_sdram_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        copying;
    logic [31:0] src_addr = '0;
    logic [31:0] dest_addr = '0;
    logic [31:0] num_words = '0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;

    int checks = 0;
    int errors = 0;

    sdram_master dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable               (enable),
        .copying              (copying),
        .src_addr             (src_addr),
        .dest_addr            (dest_addr),
        .num_words            (num_words),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    always #5 clk = ~clk;

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
    } op_t;

    op_t         exp_q[$];
    logic        m_busy  = 1'b0;   // copy in progress
    logic        m_done  = 1'b0;   // copy finished, waiting for enable to drop
    logic        m_await = 1'b0;   // read accepted, data not yet returned
    logic [31:0] m_wdata = '0;     // data the pending write must carry

    task automatic model_step();
        op_t op;
        if (rst) begin
            exp_q.delete();
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_await = 1'b0;
            m_wdata = '0;
            return;
        end
        // compare outputs for the current cycle
        chk1("copying", copying, m_busy);
        chk1("rd_wr_exclusive", master_read & master_write, 1'b0);
        if (m_busy && !m_await) begin
            chk1("model_read", master_read, !exp_q[0].wr);
            chk1("model_write", master_write, exp_q[0].wr);
            chk32("model_address", master_address, exp_q[0].addr);
            if (exp_q[0].wr) chk32("model_writedata", master_writedata, m_wdata);
        end else begin
            chk1("model_read_idle", master_read, 1'b0);
            chk1("model_write_idle", master_write, 1'b0);
        end
        // advance the model across the coming rising edge
        if (m_done) begin
            if (!enable) m_done = 1'b0;
        end else if (!m_busy) begin
            if (enable) begin
                for (int k = 0; k < int'(num_words); k++) begin
                    op.wr = 1'b0; op.addr = src_addr + 32'(4 * k);  exp_q.push_back(op);
                    op.wr = 1'b1; op.addr = dest_addr + 32'(4 * k); exp_q.push_back(op);
                end
                if (num_words == 32'd0) m_done = 1'b1;
                else                    m_busy = 1'b1;
            end
        end else if (m_await) begin
            if (master_readdatavalid) begin
                m_wdata = master_readdata;
                m_await = 1'b0;
            end
        end else if (!master_waitrequest) begin
            op = exp_q.pop_front();
            if (!op.wr) m_await = 1'b1;
            else if (exp_q.size() == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the edge into the read request of a word.
    task automatic do_word(logic [31:0] rd_a, logic [31:0] wr_a, logic [31:0] d,
                           int rd_stall, int lat, int wr_stall);
        chk1("word_read_start", master_read, 1'b1);
        chk32("word_read_addr", master_address, rd_a);
        master_waitrequest = 1'b1;
        for (int s = 0; s < rd_stall; s++) begin
            tick();
            chk32("read_held_addr", master_address, rd_a);
        end
        master_waitrequest = 1'b0;
        tick();
        chk1("read_dropped", master_read, 1'b0);
        chk1("no_write_in_wait", master_write, 1'b0);
        master_waitrequest = 1'b1;
        repeat (lat) tick();
        master_readdatavalid = 1'b1;
        master_readdata = d;
        tick();
        master_readdatavalid = 1'b0;
        master_readdata = 32'h0BAD0BAD;
        chk1("word_write_start", master_write, 1'b1);
        chk32("word_write_addr", master_address, wr_a);
        chk32("word_write_data", master_writedata, d);
        for (int s = 0; s < wr_stall; s++) begin
            tick();
            chk32("write_held_addr", master_address, wr_a);
            chk32("write_held_data", master_writedata, d);
        end
        master_waitrequest = 1'b0;
        tick();
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        chk1("rst_read", master_read, 1'b0);
        chk1("rst_write", master_write, 1'b0);
        chk1("rst_copying", copying, 1'b0);
        chk32("rst_address", master_address, 32'h0);
        chk32("rst_writedata", master_writedata, 32'h0);
        rst = 1'b0;
        tick();

        // two-word copy with read stall, delayed data, and write stalls
        src_addr = 32'h11110000;
        dest_addr = 32'h2222DDD0;
        num_words = 32'd2;
        master_waitrequest = 1'b1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk1("start_copying", copying, 1'b1);
        do_word(32'h11110000, 32'h2222DDD0, 32'hCEECBEEF, 5, 5, 3);
        do_word(32'h11110004, 32'h2222DDD4, 32'hCEECBEEF, 1, 0, 30);
        chk1("end_read", master_read, 1'b0);
        chk1("end_write", master_write, 1'b0);
        chk1("end_copying", copying, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk1("quiet_after_copy", master_read | master_write, 1'b0);
        end

        // zero-length copy with enable held
        num_words = 32'd0;
        enable = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk1("zero_copying", copying, 1'b0);
            chk1("zero_bus", master_read | master_write, 1'b0);
            tick();
        end
        enable = 1'b0;
        tick();

        // reset while waiting for read data
        src_addr = 32'h00000040;
        dest_addr = 32'h00000080;
        num_words = 32'd3;
        master_waitrequest = 1'b0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk32("abort_read_addr", master_address, 32'h00000040);
        tick();
        chk1("abort_in_wait", copying, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk1("async_rst_read", master_read, 1'b0);
        chk1("async_rst_write", master_write, 1'b0);
        chk1("async_rst_copying", copying, 1'b0);
        chk32("async_rst_addr", master_address, 32'h0);
        chk32("async_rst_wdata", master_writedata, 32'h0);
        tick();
        rst = 1'b0;

        // restart from word 0 with address wrap
        src_addr = 32'hFFFFFFFC;
        dest_addr = 32'hFFFFFFF8;
        num_words = 32'd2;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        do_word(32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345678, 0, 2, 0);
        do_word(32'h00000000, 32'hFFFFFFFC, 32'h9ABCDEF0, 2, 1, 1);
        chk1("wrap_end_copying", copying, 1'b0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
